// File: rtl/updown_counter_div_pkg.sv
// Shared constants for the up/down counter and its prescaler.
// Direction encoding and default sizes live here so display blocks agree on them.
package updown_counter_div_pkg;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    localparam int DEF_WIDTH    = 4;
    localparam int DEF_DIV_BITS = 23;
    localparam int SIM_DIV_BITS = 2;

endpackage

// File: rtl/updown_counter_div_tick_gen.sv
// Free-running prescaler issuing a one-cycle enable tick every 2^DIV_BITS clocks.
// tick_now flags the edge on which the registered tick rises; clr restarts the period.
module tick_gen #(
    parameter int DIV_BITS = 23
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick_now,
    output logic tick
);

    logic [DIV_BITS-1:0] div;

    assign tick_now = &div;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            div  <= '0;
            tick <= 1'b0;
        end else begin
            div  <= div + 1'b1;
            tick <= tick_now;
        end
    end

endmodule

// File: rtl/updown_counter_div.sv
// Loadable up/down counter stepped by an internal prescaler tick, with wrap or
// saturate at the ends and a registered terminal-count pulse.
module updown_counter_div
    import updown_counter_div_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DIV_BITS = DEF_DIV_BITS,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             tc
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_MIN = '0;

    logic tick_now;

    // Load also restarts the prescaler so the next step is a full period away.
    tick_gen #(
        .DIV_BITS(DIV_BITS)
    ) u_tick_gen (
        .clk     (clk),
        .reset   (reset),
        .clr     (load),
        .tick_now(tick_now),
        .tick    (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            tc    <= 1'b0;
        end else if (load) begin
            count <= load_val;
            tc    <= 1'b0;
        end else begin
            tc <= 1'b0;
            if (tick_now && en) begin
                if (up_dn == DIR_UP) begin
                    if (count == CNT_MAX) begin
                        tc    <= 1'b1;
                        count <= (SATURATE != 0) ? CNT_MAX : CNT_MIN;
                    end else begin
                        count <= count + 1'b1;
                    end
                end else begin
                    if (count == CNT_MIN) begin
                        tc    <= 1'b1;
                        count <= (SATURATE != 0) ? CNT_MIN : CNT_MAX;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_updown_counter_div.sv
// Directed bench for updown_counter_div: a wrapping and a saturating instance
// share one stimulus; outputs are sampled 1 time unit after each rising edge.
module tb_updown_counter_div;
    import updown_counter_div_pkg::*;

    localparam int W = 4;

    logic         clk;
    logic         reset;
    logic         en;
    logic         up_dn;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] count_w, count_s;
    logic         tick_w, tick_s;
    logic         tc_w, tc_s;

    int tests_run = 0;
    int tests_failed = 0;
    logic [W-1:0] exp_q[$];

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    updown_counter_div #(.WIDTH(W), .DIV_BITS(SIM_DIV_BITS), .SATURATE(0)) dut_w (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .count(count_w), .tick(tick_w), .tc(tc_w)
    );

    updown_counter_div #(.WIDTH(W), .DIV_BITS(SIM_DIV_BITS), .SATURATE(1)) dut_s (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .count(count_s), .tick(tick_s), .tc(tc_s)
    );

    task automatic check(input string tag, input int obs, input int exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // driver tasks
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input logic dir);
        reset = 1'b1; load = 1'b0; load_val = '0; en = 1'b0; up_dn = dir;
        step(2);
        reset = 1'b0;
        en = 1'b1;
    endtask

    task automatic do_load(input logic [W-1:0] v, input logic dir, input logic e);
        load = 1'b1; load_val = v; up_dn = dir; en = e;
        step(1);
        load = 1'b0;
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; up_dn = DIR_UP; load = 1'b0; load_val = '0;

        // up count with wrap
        do_reset(DIR_UP);
        check("rst_count", int'(count_w), 0);
        check("rst_tick", int'(tick_w), 0);
        check("rst_tc", int'(tc_w), 0);
        for (int k = 1; k <= 15; k++) exp_q.push_back(W'(k));
        exp_q.push_back(4'd0);
        for (int k = 1; k <= 16; k++) begin
            step(3);
            check("up_tick_low", int'(tick_w), 0);
            step(1);
            check("up_count", int'(count_w), int'(exp_q.pop_front()));
            check("up_tick_high", int'(tick_w), 1);
            check("up_tc", int'(tc_w), (k == 16) ? 1 : 0);
            if (k == 16) begin
                check("sat_up_hold_end", int'(count_s), 15);
                check("sat_up_tc_end", int'(tc_s), 1);
            end
        end
        step(1);
        check("up_tc_single", int'(tc_w), 0);
        check("up_after_wrap", int'(count_w), 0);

        // down count with wrap; saturating copy holds at 0
        do_reset(DIR_DN);
        step(4);
        check("dn_wrap_count", int'(count_w), 15);
        check("dn_wrap_tc", int'(tc_w), 1);
        check("dn_sat_count", int'(count_s), 0);
        check("dn_sat_tc", int'(tc_s), 1);
        step(1);
        check("dn_tc_single", int'(tc_w), 0);
        step(3);
        check("dn_count_14", int'(count_w), 14);
        check("dn_tc_low", int'(tc_w), 0);

        // load mid-period at edge 6
        do_reset(DIR_UP);
        step(4);
        check("ld_pre_count", int'(count_w), 1);
        step(1);
        do_load(4'd9, DIR_UP, 1'b1);
        check("ld_count", int'(count_w), 9);
        check("ld_tick", int'(tick_w), 0);
        check("ld_tc", int'(tc_w), 0);
        step(2);
        check("ld_no_step_e8", int'(count_w), 9);
        check("ld_no_tick_e8", int'(tick_w), 0);
        step(2);
        check("ld_step_e10", int'(count_w), 10);
        check("ld_tick_e10", int'(tick_w), 1);

        // reset dominates load
        do_load(4'd5, DIR_UP, 1'b1);
        check("rd_pre_count", int'(count_w), 5);
        reset = 1'b1; load = 1'b1; load_val = 4'd7;
        step(1);
        check("rd_count", int'(count_w), 0);
        check("rd_tick", int'(tick_w), 0);
        check("rd_tc", int'(tc_w), 0);
        reset = 1'b0; load = 1'b0;
        step(3);
        check("rd_no_tick_e3", int'(tick_w), 0);
        check("rd_count_e3", int'(count_w), 0);
        step(1);
        check("rd_tick_e4", int'(tick_w), 1);
        check("rd_count_e4", int'(count_w), 1);

        // enable low: tick keeps running, count frozen
        do_load(4'd3, DIR_UP, 1'b0);
        for (int i = 1; i <= 40; i++) begin
            step(1);
            check("en0_tick", int'(tick_w), (i % 4 == 0) ? 1 : 0);
            check("en0_count", int'(count_w), 3);
            check("en0_tc", int'(tc_w), 0);
        end
        en = 1'b1;
        step(3);
        check("reen_pre", int'(count_w), 3);
        step(1);
        check("reen_count", int'(count_w), 4);
        check("reen_tick", int'(tick_w), 1);

        // saturate up from 14; wrapping copy goes to 0
        do_load(4'd14, DIR_UP, 1'b1);
        step(4);
        check("sat_up_15", int'(count_s), 15);
        check("sat_up_tc0", int'(tc_s), 0);
        step(4);
        check("sat_up_hold", int'(count_s), 15);
        check("sat_up_tc1", int'(tc_s), 1);
        check("wrap_up_0", int'(count_w), 0);
        step(1);
        check("sat_up_tc_single", int'(tc_s), 0);
        step(3);
        check("sat_up_hold2", int'(count_s), 15);
        check("sat_up_tc2", int'(tc_s), 1);

        // saturate down at 0
        do_load(4'd0, DIR_DN, 1'b1);
        step(4);
        check("sat_dn_hold", int'(count_s), 0);
        check("sat_dn_tc1", int'(tc_s), 1);
        step(1);
        check("sat_dn_tc_single", int'(tc_s), 0);
        step(3);
        check("sat_dn_hold2", int'(count_s), 0);
        check("sat_dn_tc2", int'(tc_s), 1);

        // direction change between ticks applies on the next tick only
        do_load(4'd8, DIR_UP, 1'b1);
        step(2);
        up_dn = DIR_DN;
        check("dir_mid_count", int'(count_w), 8);
        step(2);
        check("dir_new_step", int'(count_w), 7);

        // final report
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/updown_counter_div.md
Name: updown_counter_div

Overview:
- Loadable up/down counter, one clock domain, driven by an internal prescaler.
- It is the reverse-direction counterpart of the board's free-running up counter, and drives the same LED/7-seg outputs.
- The prescaler issues a one-cycle enable tick every 2^DIV_BITS clocks. No derived clock is created: every flop runs on clk.
- The counter steps up or down on each tick, with wrap or saturate behaviour at the ends and a terminal-count pulse.

Parameters:
- WIDTH, 4: counter width in bits.
- DIV_BITS, 23: prescaler width. Tick period is 2^DIV_BITS clk cycles. Use 2 for simulation.
- SATURATE, 0: 0 = wrap at the ends; 1 = hold at the ends.

Ports:
- clk, input, 1: system clock; all logic on its rising edge.
- reset, input, 1: synchronous, active-high reset.
- en, input, 1: count enable, sampled on tick edges.
- up_dn, input, 1: direction; 1 = up, 0 = down. Sampled on the step edge.
- load, input, 1: synchronous parallel load.
- load_val, input, WIDTH: value written by load.
- count, output, WIDTH: current count, registered.
- tick, output, 1: registered prescaler pulse.
- tc, output, 1: registered terminal-count pulse.

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high (ports clk, reset).
- Reset, on a rising edge with reset=1:
  - div=0, count=0, tick=0, tc=0.
  - Reset dominates load, en and tick.
- Prescaler:
  - div (DIV_BITS wide) increments every clk and wraps naturally.
  - A "tick edge" is any edge where div == all-ones.
  - On a tick edge, tick <= 1; on every other edge, tick <= 0.
  - So tick is high for exactly one cycle per period, independent of en.
- First step timing: after reset release, the first tick edge is the 2^DIV_BITS-th rising edge. With DIV_BITS=2, that is edge 4.
- Load priority (over stepping):
  - load=1 (and reset=0): count <= load_val on that edge.
  - div <= 0, tick <= 0, tc <= 0.
  - The next tick edge is therefore 2^DIV_BITS edges later.
  - Load is not gated by en or tick.
- Step: tick edge, en=1, load=0:
  - up_dn=1: count <= count+1.
  - up_dn=0: count <= count-1.
  - WIDTH-bit arithmetic.
- Boundary, "at boundary" means count == 2^WIDTH-1 when up, or count == 0 when down:
  - SATURATE=0: count wraps (max -> 0, 0 -> max).
  - SATURATE=1: count holds.
  - In both modes, tc <= 1 on that edge.
- tc timing:
  - tc <= 0 on every other edge.
  - tc is a single-cycle pulse, coincident with the cycle in which count shows the wrapped or held value.
- en=0: count holds and tc stays 0; div and tick keep running.
- Direction change: takes effect on the next tick edge only, with no glitch between ticks.
- Output latency: count, tick and tc all update on the same edge. There is no combinational path from any input to any output.

Decomposition:
- Shared package holds:
  - DIR_UP = 1'b1 and DIR_DN = 1'b0.
  - Default constants for WIDTH, DIV_BITS and SIM_DIV_BITS = 2.
- One sub-module, tick_gen:
  - Parameter DIV_BITS.
  - Ports clk, reset, clr, tick_now (combinational, div == all-ones), tick (registered).
  - clr is driven by load.
  - The parent instantiates it, and it is reused by future display-scan blocks.
- Counter, direction, boundary and tc logic stay in the parent.

Test Plan (DIV_BITS=2, WIDTH=4):
- Up count with wrap: reset 2 cycles, then en=1, up_dn=1 -> count=1 after edge 4, +1 every 4 edges; 15 -> 0 at edge 64 with tc=1 for that cycle only; tick high every 4th cycle.
- Down count with wrap: reset, en=1, up_dn=0 -> count 0 -> 15 at edge 4 with tc pulse, then 14 at edge 8.
- Load mid-period: load=1, load_val=9 at edge 6 -> count=9 at edge 6; next step (10) at edge 10, not edge 8.
- Saturate up: SATURATE=1, load 14, up -> 15 after 4 edges, then held at 15 with tc pulse every 4 edges.
- Saturate down: SATURATE=1, from 0 going down -> stays 0, tc pulses.
- Reset dominance: reset=1 together with load=1, load_val=7 while count=5 -> count=0, tick=0, tc=0; first tick 4 edges after release.
- Enable low: en=0 from count=3 -> tick still pulses every 4 cycles; count stays 3 and tc stays 0 for 40 cycles.
- Re-enable: en back to 1 -> count=4 on the next tick edge.
